md_issue_ctrl: RTL

- Execute-stage issue controller that drives mul_div and is fed from the D/E pipeline register.
- Decodes the mult/div-class instruction in E and generates single-cycle Start/We pulses, Op and HiLo for mul_div.
- Tracks operation latency with its own state machine and counter, and stalls the D stage on any HI/LO-class instruction while an operation is in flight.
- Muxes HI/LO for mfhi/mflo results.

---
 rtl/md_pkg.sv | 48 ++++
 rtl/md_lat_counter.sv | 34 +++
 rtl/md_issue_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the mult/div issue path.
//   - MD_*  : class encoding of the HI/LO-related instruction in a pipe stage
//   - OP_*  : operation codes understood by mul_div
//   - ST_*  : issue-controller state encoding
//   - helpers to classify an instruction class and map it to an OP code
package md_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULTU = 4'd1;
    localparam logic [3:0] MD_MULT  = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd3;
    localparam logic [3:0] MD_DIV   = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // True for the four classes that occupy mul_div for several cycles.
    function automatic logic md_is_muldiv(input logic [3:0] md_type);
        return (md_type == MD_MULTU) || (md_type == MD_MULT) ||
               (md_type == MD_DIVU)  || (md_type == MD_DIV);
    endfunction

    function automatic logic md_is_mul(input logic [3:0] md_type);
        return (md_type == MD_MULTU) || (md_type == MD_MULT);
    endfunction

    function automatic logic [1:0] md_op(input logic [3:0] md_type);
        logic [1:0] op;
        case (md_type)
            MD_MULT: op = OP_MULT;
            MD_DIVU: op = OP_DIVU;
            MD_DIV:  op = OP_DIV;
            default: op = OP_MULTU;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/md_lat_counter.sv
// md_lat_counter: loadable down-counter with a zero flag.
//   Clk     in  clock, rising edge
//   Rst     in  synchronous active-high reset (count -> 0)
//   Load    in  load LoadVal this cycle (has priority over Dec)
//   LoadVal in  value to load
//   Dec     in  decrement this cycle (held at 0, never wraps)
//   Count   out current count
//   Zero    out Count == 0
module md_lat_counter #(
    parameter int W = 5
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Load,
    input  logic [W-1:0] LoadVal,
    input  logic         Dec,
    output logic [W-1:0] Count,
    output logic         Zero
);

    always_ff @(posedge Clk) begin
        // NOTE: sequential state is assigned with <= so every flop samples
        // the pre-edge values, independent of block ordering.
        if (Rst)
            Count <= '0;
        else if (Load)
            Count <= LoadVal;
        else if (Dec && (Count != '0))
            Count <= Count - 1'b1;
    end

    assign Zero = (Count == '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: execute-stage issue controller for mul_div.
//   Clk, Rst   clock / synchronous active-high reset
//   E_MdType   class of the instruction in E;  E_Valid: E is not a bubble
//   E_Hold     E is frozen; the same instruction is presented again
//   D_MdType   class of the instruction in D
//   Busy, HI, LO from mul_div
//   Start/Op   one-cycle start pulse and operation code to mul_div
//   We/HiLo    one-cycle HI/LO write pulse (mthi/mtlo) and its target
//   Stall      freeze PC and F/D, bubble into E
//   MdResult   HI for mfhi, LO for mflo, else 0
//   InFlight   an operation is being tracked (state != IDLE)
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [3:0]  E_MdType,
    input  logic        E_Valid,
    input  logic        E_Hold,
    input  logic [3:0]  D_MdType,
    input  logic        Busy,
    input  logic [31:0] HI,
    input  logic [31:0] LO,
    output logic        Start,
    output logic [1:0]  Op,
    output logic        We,
    output logic        HiLo,
    output logic        Stall,
    output logic [31:0] MdResult,
    output logic        InFlight
);

    localparam logic [4:0] MUL_LOAD = 5'(MUL_LAT - 1);
    localparam logic [4:0] DIV_LOAD = 5'(DIV_LAT - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       issued;
    logic       idle;
    logic       e_is_mt;
    logic [4:0] cnt;
    logic       cnt_zero;

    assign idle    = (state == ST_IDLE);
    assign e_is_mt = (E_MdType == MD_MTHI) || (E_MdType == MD_MTLO);

    // Pulses are gated by Rst so a reset cycle never launches anything;
    // gating by issued gives one pulse per instruction while E is held.
    assign Start = !Rst && E_Valid && md_is_muldiv(E_MdType) && !issued && idle;
    assign Op    = Start ? md_op(E_MdType) : OP_MULTU;
    assign We    = !Rst && E_Valid && e_is_mt && !issued && idle;
    assign HiLo  = We && (E_MdType == MD_MTHI);

    assign Stall    = !Rst && (D_MdType != MD_NONE) && (Start || !idle);
    assign InFlight = !idle;

    always_comb begin
        MdResult = '0;
        if (E_Valid && (E_MdType == MD_MFHI))
            MdResult = HI;
        else if (E_Valid && (E_MdType == MD_MFLO))
            MdResult = LO;
    end

    // A pulse taken on a held cycle is remembered until E advances; if E
    // advances in the pulse cycle itself there is nothing to remember.
    always_ff @(posedge Clk) begin
        if (Rst)
            issued <= 1'b0;
        else if (!E_Hold)
            issued <= 1'b0;
        else if (Start || We)
            issued <= 1'b1;
    end

    md_lat_counter #(.W(5)) u_lat (
        .Clk     (Clk),
        .Rst     (Rst),
        .Load    (Start),
        .LoadVal (md_is_mul(E_MdType) ? MUL_LOAD : DIV_LOAD),
        .Dec     (state == ST_RUN),
        .Count   (cnt),
        .Zero    (cnt_zero)
    );

    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt
        // unassigned, which would infer a latch.
        state_nxt = state;
        case (state)
            ST_IDLE:  if (Start)     state_nxt = ST_RUN;
            ST_RUN:   if (cnt_zero)  state_nxt = ST_DRAIN;
            // mul_div may drop Busy later than our own latency estimate.
            ST_DRAIN: if (!Busy)     state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

endmodule
